dist_calc: RTL and testbench

Pipelined comparator that scores how close two 2x2 complex fixed-point matrices are, for the gate-synthesis search. It computes the squared magnitude of the Frobenius inner product, |Σ conj(a_ij)·b_ij|², and scales it to a 38-bit unsigned result. It sits between the candidate-matrix generator and the search controller: the generator presents two matrices with `ready`, and the controller consumes `dist2` when `finished` is high.

---
 rtl/dist_pkg.sv | 29 ++
 rtl/cmul_conj.sv | 40 ++++
 rtl/dist_calc.sv | 74 +++++++
 tb/tb_dist_calc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared types, widths and helpers for the matrix-distance pipeline.
package dist_pkg;

  localparam int ELEM_W      = 19;
  localparam int PROD_W      = 39;
  localparam int SUM_W       = 41;
  localparam int PART_W      = 20;
  localparam int TRACE_SHIFT = 21;
  localparam int DIST_W      = 38;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t [0:1][0:1][0:1]    mtx_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [PART_W-1:0] part_t;
  typedef logic signed [DIST_W:0]   wide_t;

  // A product sum reaches +2^37 when every part is -2^18, so it needs 39 signed bits.
  function automatic logic [DIST_W-1:0] mag2(input part_t re, input part_t im);
    wide_t r;
    wide_t i;
    wide_t s;
    r = wide_t'(re);
    i = wide_t'(im);
    s = r * r + i * i;
    return s[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/cmul_conj.sv
// Registered conj(a)*b complex multiplier: four full-precision products, two adders.
module cmul_conj
  import dist_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  elem_t a_re,
  input  elem_t a_im,
  input  elem_t b_re,
  input  elem_t b_im,
  output prod_t p_re,
  output prod_t p_im
);

  prod_t ar;
  prod_t ai;
  prod_t br;
  prod_t bi;
  prod_t re_sum;
  prod_t im_sum;

  assign ar     = prod_t'(a_re);
  assign ai     = prod_t'(a_im);
  assign br     = prod_t'(b_re);
  assign bi     = prod_t'(b_im);
  assign re_sum = ar * br + ai * bi;
  assign im_sum = ar * bi - ai * br;

  // Product register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= re_sum;
      p_im <= im_sum;
    end
  end

endmodule

// File: rtl/dist_calc.sv
// Three-stage pipeline scoring |tr(A^H B)|^2 between two 2x2 complex matrices.
module dist_calc
  import dist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  mtx_t              mtx_a,
  input  mtx_t              mtx_b,
  input  logic              ready,
  output logic [DIST_W-1:0] dist2,
  output logic              finished
);

  prod_t p_re [4];
  prod_t p_im [4];
  sum_t  sum_re;
  sum_t  sum_im;
  part_t tr_r;
  part_t ti_r;
  logic  valid1_r;
  logic  valid2_r;

  for (genvar i = 0; i < 2; i++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      cmul_conj u_cmul (
        .clk  (clk),
        .reset(reset),
        .a_re (mtx_a[i][j][0]),
        .a_im (mtx_a[i][j][1]),
        .b_re (mtx_b[i][j][0]),
        .b_im (mtx_b[i][j][1]),
        .p_re (p_re[i*2+j]),
        .p_im (p_im[i*2+j])
      );
    end
  end

  // Trace sums; 41 bits hold 4 * 2^37 without wrapping
  always_comb begin
    sum_re = sum_t'(p_re[0]) + sum_t'(p_re[1]) + sum_t'(p_re[2]) + sum_t'(p_re[3]);
    sum_im = sum_t'(p_im[0]) + sum_t'(p_im[1]) + sum_t'(p_im[2]) + sum_t'(p_im[3]);
  end

  // Valid pipe and scaled trace register (arithmetic shift floors toward -inf)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid1_r <= 1'b0;
      valid2_r <= 1'b0;
      tr_r     <= '0;
      ti_r     <= '0;
    end else begin
      valid1_r <= ready;
      valid2_r <= valid1_r;
      tr_r     <= part_t'(sum_re >>> TRACE_SHIFT);
      ti_r     <= part_t'(sum_im >>> TRACE_SHIFT);
    end
  end

  // Output stage: dist2 only loads on a valid result and otherwise holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dist2    <= '0;
      finished <= 1'b0;
    end else begin
      finished <= valid2_r;
      if (valid2_r) begin
        dist2 <= mag2(tr_r, ti_r);
      end else begin
        dist2 <= dist2;
      end
    end
  end

endmodule

// File: tb/tb_dist_calc.sv
// Directed-vector bench for dist_calc with hand-computed expected distances.
module tb_dist_calc;
  import dist_pkg::*;

  logic              clk;
  logic              reset;
  mtx_t              mtx_a;
  mtx_t              mtx_b;
  logic              ready;
  logic [DIST_W-1:0] dist2;
  logic              finished;

  int n_vec  = 0;
  int n_miss = 0;

  // TR = 38274859410 -> tr = 18250, TI = -8184829320 -> ti = -3903
  localparam longint REF_D2   = 64'd348295909;
  localparam longint IDENT_D2 = 64'd268435456;
  // all parts -2^18: TR = 4 * 2^37 = 2^39 -> tr = 2^18 -> tr^2 = 2^36
  localparam longint WORST_D2 = 64'd68719476736;

  dist_calc dut (
    .clk     (clk),
    .reset   (reset),
    .mtx_a   (mtx_a),
    .mtx_b   (mtx_b),
    .ready   (ready),
    .dist2   (dist2),
    .finished(finished)
  );

  task automatic clockGen();
    clk   = 1'b0;
    reset = 1'b0;
    fork
      forever #5 clk = ~clk;
      #15 reset = 1'b1;
    join_none
  endtask

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mtx_t mk(input int r00, input int i00, input int r01, input int i01,
                              input int r10, input int i10, input int r11, input int i11);
    mtx_t m;
    m[0][0][0] = elem_t'(r00); m[0][0][1] = elem_t'(i00);
    m[0][1][0] = elem_t'(r01); m[0][1][1] = elem_t'(i01);
    m[1][0][0] = elem_t'(r10); m[1][0][1] = elem_t'(i10);
    m[1][1][0] = elem_t'(r11); m[1][1][1] = elem_t'(i11);
    return m;
  endfunction

  task automatic check_out(input string tag, input logic exp_fin, input longint exp_d2);
    check_val({tag, "_fin"}, longint'(finished), longint'(exp_fin));
    check_val({tag, "_d2"}, longint'(dist2), exp_d2);
  endtask

  task automatic run_pair(input string tag, input mtx_t a, input mtx_t b, input longint exp_d2);
    mtx_a = a;
    mtx_b = b;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out(tag, 1'b1, exp_d2);
  endtask

  mtx_t ref_a, ref_b, ident, zero_m, worst;

  initial begin
    ref_a  = mk(104176, 159610, -49594, 117945, 236953, 16111, -229004, 99439);
    ref_b  = mk(195433, 46169, -83420, 213816, -143459, 171112, -7539, 107609);
    ident  = mk(131072, 0, 0, 0, 0, 0, 131072, 0);
    zero_m = mk(0, 0, 0, 0, 0, 0, 0, 0);
    worst  = mk(-262144, -262144, -262144, -262144, -262144, -262144, -262144, -262144);

    mtx_a = ref_a;
    mtx_b = ref_b;
    ready = 1'b1;
    clockGen();

    #2;
    check_out("reset", 1'b0, 64'd0);

    #48;
    check_out("ref_50ns", 1'b1, REF_D2);

    run_pair("identity", ident, ident, IDENT_D2);
    run_pair("b_zero", ref_a, zero_m, 64'd0);
    run_pair("worst", worst, worst, WORST_D2);
    check_val("worst_hold_fin", longint'(finished), 64'd1);

    // Drain: bubble reaches the output three edges later and dist2 holds
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out("drain", 1'b0, WORST_D2);

    // Single-cycle ready pulse with the reference pair
    mtx_a = ref_a;
    mtx_b = ref_b;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    mtx_b = zero_m;
    @(posedge clk);
    @(negedge clk);
    check_out("pulse_early", 1'b0, WORST_D2);
    @(posedge clk);
    @(negedge clk);
    check_out("pulse_out", 1'b1, REF_D2);
    @(posedge clk);
    @(negedge clk);
    check_out("pulse_after", 1'b0, REF_D2);

    // Asynchronous reset with results in flight
    mtx_a = ident;
    mtx_b = ident;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 64'd0);
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_out("post_rst", 1'b0, 64'd0);
    end

    ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("refill_fin", longint'(finished), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check_out("refill", 1'b1, IDENT_D2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
